// File: rtl/stream_max_min_tracker.sv
// stream_max_min_tracker: per-frame running max/min/beat-count over a valid/ready stream.
// Define MAXIDX_EN to add the out_max_idx port and its index register.
module stream_max_min_tracker #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_max,
    output logic [WIDTH-1:0] out_min,
    output logic [CNT_W-1:0] out_cnt
`ifdef MAXIDX_EN
    ,
    output logic [CNT_W-1:0] out_max_idx
`endif
);
    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
    state_t           r_state;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_max;
    logic [WIDTH-1:0] r_min;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_beat;
`ifdef MAXIDX_EN
    logic [CNT_W-1:0] r_idx;
`endif
    assign w_beat    = in_valid && r_in_ready;
    assign w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + 1'b1;
    // in_ready is registered so it drops during reset and only depends on state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_max       <= '0;
            r_min       <= '0;
            r_cnt       <= '0;
`ifdef MAXIDX_EN
            r_idx       <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    r_in_ready <= 1'b1;
                    if (w_beat) begin
                        r_max <= in_data;
                        r_min <= in_data;
                        r_cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
`ifdef MAXIDX_EN
                        r_idx <= '0;
`endif
                        r_state     <= in_last ? HOLD : ACCUM;
                        r_in_ready  <= !in_last;
                        r_out_valid <= in_last;
                    end
                end
                ACCUM: begin
                    if (w_beat) begin
                        if (in_data > r_max) begin
                            r_max <= in_data;
`ifdef MAXIDX_EN
                            r_idx <= r_cnt;
`endif
                        end
                        if (in_data < r_min) r_min <= in_data;
                        r_cnt       <= w_cnt_inc;
                        r_state     <= in_last ? HOLD : ACCUM;
                        r_in_ready  <= !in_last;
                        r_out_valid <= in_last;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_in_ready  <= 1'b1;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end
    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_max   = r_max;
    assign out_min   = r_min;
    assign out_cnt   = r_cnt;
`ifdef MAXIDX_EN
    assign out_max_idx = r_idx;
`endif
endmodule
